// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and one-frame-at-a-time launch controller feeding the UART transmitter.
// Define UART_TXFIFO_OVF_EN to add the sticky overflow flag (ovf_o) and its clear input (ovf_clr_i).
module uart_tx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_en_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic                       tx_en_i,
   input  logic                       flush_i,
   input  logic                       tx_rdy_i,
`ifdef UART_TXFIFO_OVF_EN
   input  logic                       ovf_clr_i,
   output logic                       ovf_o,
`endif
   output logic                       tx_start_o,
   output logic [DATA_W-1:0]          tx_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       busy_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              wr_ok, pop;

   assign full_o  = (count == FULL_CNT);
   assign empty_o = (count == '0);
   assign count_o = count;
   assign busy_o  = (state != IDLE);

   // Full is the registered flag, so a pop in the same cycle never frees room for a write.
   assign wr_ok = wr_en_i && !full_o && !flush_i;
   assign pop   = (state == IDLE) && tx_en_i && !empty_o && !flush_i;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pop) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = WAIT;
         WAIT:    if (tx_rdy_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the storage array has no reset; entries are only read after being written, and
   // leaving them unreset lets synthesis map the array onto RAM.
   always_ff @(posedge clk_i) begin
      if (rst_i && wr_ok) mem[wr_ptr] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         tx_start_o <= 1'b0;
         tx_data_o  <= '0;
      end else begin
         tx_start_o <= pop;
         if (pop) tx_data_o <= mem[rd_ptr];
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_ok, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

`ifdef UART_TXFIFO_OVF_EN
   // Any attempted write while full sets the flag; a set wins over a same-cycle clear.
   always_ff @(posedge clk_i) begin
      if (!rst_i)                   ovf_o <= 1'b0;
      else if (wr_en_i && full_o)   ovf_o <= 1'b1;
      else if (ovf_clr_i)           ovf_o <= 1'b0;
   end
`endif

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit buffer and launch controller directly upstream of the UART transmitter (as_tx).
- Accepts bytes from the bus side into a DEPTH-entry FIFO.
- Hands bytes one at a time to the transmitter via a single-cycle start pulse with the data.
- Waits for the transmitter's one-cycle ready pulse before launching the next byte.

Parameters:
- DATA_W, default uart_width (8): width of each FIFO entry and of the transmitter data path.
- DEPTH, default 16: number of FIFO entries; must be a power of two, 2 to 256.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- wr_en_i  in  1  write strobe; one byte per cycle.
- wr_data_i  in  DATA_W  byte to enqueue.
- tx_en_i  in  1  launch enable; 0 = hold FIFO contents, launch nothing new.
- flush_i  in  1  discard all queued bytes.
- tx_rdy_i  in  1  one-cycle frame-done pulse from the transmitter (rdy_o).
- tx_start_o  out  1  one-cycle start pulse to the transmitter (start_i).
- tx_data_o  out  DATA_W  byte to the transmitter (data_i); valid while tx_start_o=1.
- full_o  out  1  FIFO full (count == DEPTH).
- empty_o  out  1  FIFO empty (count == 0).
- count_o  out  $clog2(DEPTH)+1  number of queued bytes, excluding the byte in flight.
- busy_o  out  1  a frame is launched and not yet acknowledged.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - Pointers = 0, count_o = 0, empty_o = 1, full_o = 0.
  - tx_start_o = 0, tx_data_o = 0, busy_o = 0, state = IDLE.
  - Reset overrides every other input. Asserting reset mid-frame abandons the frame; tx_rdy_i pulses arriving after reset are ignored in IDLE.
- Storage: circular buffer, write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. count_o is a separate registered counter.
- Write:
  - Accepted iff wr_en_i=1 and registered full_o=0.
  - A write while full_o=1 is dropped; count and pointers are unchanged.
  - A pop in the same cycle does not make room for a write in that cycle.
- State machine (registered outputs):
  - IDLE: if tx_en_i=1, empty_o=0 and flush_i=0 -> LAUNCH. That edge loads tx_data_o with the head entry, sets tx_start_o=1, and advances the read pointer.
  - LAUNCH: lasts exactly one cycle, then -> WAIT. tx_start_o returns to 0; tx_data_o holds its value until the next launch.
  - WAIT: busy_o=1. On tx_rdy_i=1 -> IDLE. tx_rdy_i in IDLE or LAUNCH is ignored.
  - busy_o=1 in LAUNCH and WAIT.
- Latency and spacing:
  - A write into an empty FIFO while IDLE with tx_en_i=1 produces tx_start_o=1 two cycles after the write edge.
  - After tx_rdy_i, the next tx_start_o follows at the earliest 2 cycles later, so IDLE lasts at least one cycle.
  - Because of this FSM, tx_start_o is never asserted while the transmitter is mid-frame.
- Simultaneous write and pop: count unchanged, both pointers advance. Applies both when empty_o=0 and when the written byte is not the one popped.
- Flush:
  - flush_i=1 sets read pointer = write pointer and count = 0. A write in the same cycle is dropped.
  - A frame already launched completes normally; FSM goes WAIT -> IDLE.
  - No launch occurs in a flush cycle.
- tx_en_i=0: no new launch; an in-flight frame completes; writes still accepted.
- Count arithmetic:
  - +1 on accepted write only, -1 on pop only.
  - Never exceeds DEPTH, never goes below 0.

Optional Feature:
- Macro UART_TXFIFO_OVF_EN.
- When defined, the block adds:
  - Input ovf_clr_i (1).
  - Output ovf_o (1): sticky; set on any write attempt while full_o=1, cleared by ovf_clr_i=1 or reset.
  - Set has priority over a clear in the same cycle.
- When undefined: no ovf ports exist, and overflowing writes are silently dropped.

Test Plan:
- Reset then write 0xA5 with tx_en_i=1 -> tx_start_o=1 for exactly 1 cycle, 2 cycles after the write, tx_data_o=0xA5. count_o goes 1 -> 0; busy_o=1 until tx_rdy_i pulses.
- Write 0x01,0x02,0x03 back-to-back; pulse tx_rdy_i 20 cycles after each start -> three starts in order 0x01,0x02,0x03. No start while busy_o=1; empty_o=1 after the third launch.
- tx_en_i=0, write 17 bytes with DEPTH=16 -> full_o=1 after the 16th, 17th dropped, count_o=16. With UART_TXFIFO_OVF_EN: ovf_o=1 until ovf_clr_i.
- Fill 16 entries, enable, run until the pointers wrap, write 4 more -> output order preserved across the 15 -> 0 wrap, no byte lost or duplicated.
- With 5 queued and one frame in WAIT, assert flush_i -> count_o=0, empty_o=1. The in-flight frame finishes on tx_rdy_i with no further tx_start_o.
- Drive rst_i=0 for 1 cycle during WAIT with 3 queued -> all outputs at reset values next cycle. A later stray tx_rdy_i causes no start.
